// File: rtl/bcd_down_timer.sv
// Purpose: four-digit BCD countdown timer (00.00-99.99 s) with preset, pause, done and expire.
// Latency: 1 clk from any accepted input pulse to the registered digits/running/done/expire.
// Backpressure: none. Inputs are single-clk pulses. One action per cycle, priority clr > load > start_stop > tick.
//
// Ports:
//   clk, rst_n           : clock and asynchronous active-low reset
//   tick                 : 0.01 s enable pulse
//   start_stop           : start/pause toggle pulse
//   clr                  : reload the digits from the preset and return to IDLE
//   load, ld_d0..ld_d3   : capture a new preset (each digit clamped to 9)
//   d0..d3               : current count, 0.01 s digit first
//   running, done        : state levels (RUN, DONE)
//   expire               : one-clk pulse on the edge where the count reaches 00.00
module bcd_down_timer #(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick,
    input  logic       start_stop,
    input  logic       clr,
    input  logic       load,
    input  logic [3:0] ld_d0,
    input  logic [3:0] ld_d1,
    input  logic [3:0] ld_d2,
    input  logic [3:0] ld_d3,
    output logic [3:0] d0,
    output logic [3:0] d1,
    output logic [3:0] d2,
    output logic [3:0] d3,
    output logic       running,
    output logic       done,
    output logic       expire
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_PAUSE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    logic [3:0] r_d0, r_d1, r_d2, r_d3;
    logic [3:0] r_p0, r_p1, r_p2, r_p3;
    logic       r_running, r_done, r_expire;

    logic [3:0] w_n0, w_n1, w_n2, w_n3;
    logic [3:0] w_c0, w_c1, w_c2, w_c3;
    logic       w_b1, w_b2, w_b3;
    logic       w_cur_zero, w_dec_zero, w_reload;

    function automatic logic [3:0] clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 4'd9 : d;
    endfunction

    // Borrow chain: a digit borrows only when every digit below it is 0.
    always_comb begin
        w_b1 = (r_d0 == 4'd0);
        w_b2 = w_b1 && (r_d1 == 4'd0);
        w_b3 = w_b2 && (r_d2 == 4'd0);
        w_n0 = (r_d0 == 4'd0) ? 4'd9 : r_d0 - 4'd1;
        w_n1 = w_b1 ? ((r_d1 == 4'd0) ? 4'd9 : r_d1 - 4'd1) : r_d1;
        w_n2 = w_b2 ? ((r_d2 == 4'd0) ? 4'd9 : r_d2 - 4'd1) : r_d2;
        w_n3 = w_b3 ? r_d3 - 4'd1 : r_d3;
    end

    assign w_c0 = clamp9(ld_d0);
    assign w_c1 = clamp9(ld_d1);
    assign w_c2 = clamp9(ld_d2);
    assign w_c3 = clamp9(ld_d3);

    assign w_cur_zero = ({r_d3, r_d2, r_d1, r_d0} == 16'h0000);
    // The decrement lands on 00.00 exactly when the count is 00.01.
    assign w_dec_zero = ({r_d3, r_d2, r_d1, r_d0} == 16'h0001);
    // A zero preset would reload straight back to 00.00, so it falls back to DONE.
    assign w_reload   = AUTO_RELOAD && ({r_p3, r_p2, r_p1, r_p0} != 16'h0000);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_d0      <= 4'd0;
            r_d1      <= 4'd0;
            r_d2      <= 4'd0;
            r_d3      <= 4'd0;
            r_p0      <= 4'd0;
            r_p1      <= 4'd0;
            r_p2      <= 4'd0;
            r_p3      <= 4'd0;
            r_running <= 1'b0;
            r_done    <= 1'b0;
            r_expire  <= 1'b0;
        end else begin
            r_expire <= 1'b0;
            if (clr) begin
                {r_d3, r_d2, r_d1, r_d0} <= {r_p3, r_p2, r_p1, r_p0};
                r_state   <= S_IDLE;
                r_running <= 1'b0;
                r_done    <= 1'b0;
            end else if (load) begin
                // A load in RUN still claims the cycle; it just does nothing.
                if (r_state != S_RUN) begin
                    {r_p3, r_p2, r_p1, r_p0} <= {w_c3, w_c2, w_c1, w_c0};
                    {r_d3, r_d2, r_d1, r_d0} <= {w_c3, w_c2, w_c1, w_c0};
                    r_state   <= S_IDLE;
                    r_running <= 1'b0;
                    r_done    <= 1'b0;
                end
            end else if (start_stop) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_cur_zero) begin
                            r_state   <= S_RUN;
                            r_running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        r_state   <= S_PAUSE;
                        r_running <= 1'b0;
                    end
                    S_PAUSE: begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (tick && (r_state == S_RUN)) begin
                if (w_cur_zero) begin
                    // Only reachable with auto-reload: the tick after expiry restarts the count.
                    if (w_reload) begin
                        {r_d3, r_d2, r_d1, r_d0} <= {r_p3, r_p2, r_p1, r_p0};
                    end
                end else begin
                    {r_d3, r_d2, r_d1, r_d0} <= {w_n3, w_n2, w_n1, w_n0};
                    if (w_dec_zero) begin
                        r_expire <= 1'b1;
                        if (!w_reload) begin
                            r_state   <= S_DONE;
                            r_running <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end
            end
        end
    end

    assign d0      = r_d0;
    assign d1      = r_d1;
    assign d2      = r_d2;
    assign d3      = r_d3;
    assign running = r_running;
    assign done    = r_done;
    assign expire  = r_expire;

endmodule

// File: doc/bcd_down_timer.md
Name: bcd_down_timer

Overview:
- Four-digit BCD countdown timer (00.00–99.99 s); the count-down counterpart to the stopwatch up-counter chain.
- Holds a loadable preset and decrements one count (0.01 s) per tick while running.
- Borrows ripple d0→d1→d2→d3; stops at 00.00 and raises done.
- Sits between the 100 Hz tick generator and button debouncers on the input side, and the 7-segment scan driver on the output side.

Parameters:
- AUTO_RELOAD, 0: when 1, reaching 00.00 reloads the preset and keeps running instead of entering DONE. The expire pulse still fires.

Ports:
- clk  input  1  system clock (same domain as tick)
- rst_n  input  1  asynchronous active-low reset
- tick  input  1  0.01 s enable pulse, one clk wide
- start_stop  input  1  debounced one-clk pulse: start/pause toggle
- clr  input  1  one-clk pulse: reload digits from preset, go IDLE
- load  input  1  one-clk pulse: capture ld_d0..ld_d3 as new preset
- ld_d0  input  4  preset 0.01 s digit
- ld_d1  input  4  preset 0.1 s digit
- ld_d2  input  4  preset 1 s digit
- ld_d3  input  4  preset 10 s digit
- d0  output  4  current 0.01 s digit
- d1  output  4  current 0.1 s digit
- d2  output  4  current 1 s digit
- d3  output  4  current 10 s digit
- running  output  1  high in RUN state
- done  output  1  level, high in DONE state
- expire  output  1  one-clk pulse on the cycle the count reaches 00.00

Behaviour:
- Reset (rst_n=0, async): d0–d3=0; preset=0; state=IDLE; running=0; done=0; expire=0.
- States: IDLE, RUN, PAUSE, DONE. All updates occur on the rising clk edge.
- Input priority, highest first: clr > load > start_stop > tick. Exactly one action is taken per cycle.
- clr, any state: digits←preset; state→IDLE; done=0. Any simultaneous load, start_stop or tick is ignored.
- load:
  - In IDLE, PAUSE or DONE: preset←ld inputs and digits←ld inputs in the same edge; state→IDLE; done=0.
  - Any ld digit greater than 9 is clamped to 9 before storing.
  - In RUN: load is ignored.
- start_stop:
  - IDLE→RUN only if the digits are not 0000; otherwise stay in IDLE.
  - RUN→PAUSE.
  - PAUSE→RUN.
  - DONE: ignored.
- start_stop takes the cycle: a tick in the same cycle is dropped, with no decrement.
- tick in RUN, no higher-priority input: the 4-digit BCD value decrements by 1 on that edge (latency 1 clk).
  - Borrow rule: d0 0→9 borrows from d1, d1 0→9 borrows from d2, d2 0→9 borrows from d3.
  - Digits never leave the range 0–9.
- tick outside RUN: ignored.
- Expiry: when a decrement yields 0000, expire=1 for exactly that one cycle.
  - AUTO_RELOAD=0: state→DONE; done=1; digits hold 0000.
  - AUTO_RELOAD=1: digits←preset on the following tick instead of decrementing. State stays RUN and done stays 0. If preset=0000, behave as AUTO_RELOAD=0.
- running is 1 exactly when state=RUN. done is 1 exactly when state=DONE.
- Reset mid-count: async clear per the reset values above, effective immediately, independent of clk.
- Registered outputs: d0–d3, running, done, expire all come directly from flops.

Test Plan:
- Reset, then load 00.05, start, 5 ticks → digits 04,03,02,01,00; expire pulses once on the 5th tick; done=1; running=0; a 6th tick leaves 00.00.
- Load 10.00, start, 1 tick → digits 09.99 (full borrow ripple through all digits); running=1.
- Load 00.03, start, then start_stop and tick asserted together → state PAUSE, digits still 00.03; 3 further ticks → no change; start_stop → RUN.
- Load with ld_d3=4'hC, ld_d0=4'hF → digits 90.09. start_stop with digits 00.00 after reset → stays IDLE, running=0.
- In RUN at 00.07, assert load with 12.34 → ignored. Then clr → digits 00.07 (the preset), IDLE. In DONE, clr → digits restored to preset, done=0.
- AUTO_RELOAD=1, preset 00.02, start, 4 ticks → 01, 00 (expire=1), 02, 01; done never asserts. Drop rst_n mid-run → all outputs 0 immediately.
